// File: rtl/glbl_rst_pkg.sv
// ----------------------------------------------------------------------------
// glbl_rst_pkg
// Shared types and defaults for the global reset release sequencer.
//   rst_seq_st_t : sequencer FSM state (IDLE waits for work, GAP counts down
//                  the idle gap before releasing one block)
//   DEF_NUM_RST  : default number of per-block reset outputs
// ----------------------------------------------------------------------------
package glbl_rst_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      GAP  = 1'b1
   } rst_seq_st_t;

   localparam int DEF_NUM_RST = 8;

endpackage

// File: rtl/rst_prio_enc.sv
// ----------------------------------------------------------------------------
// rst_prio_enc
// Combinational lowest-set-bit finder used to pick the next block to release.
// Ports:
//   vec_i   in  NUM_RST  candidate vector
//   idx_o   out IDX_W    index of the lowest set bit (0 when none set)
//   valid_o out 1        at least one bit of vec_i is set
// ----------------------------------------------------------------------------
module rst_prio_enc
   import glbl_rst_pkg::*;
#(
   parameter int NUM_RST = DEF_NUM_RST,
   parameter int IDX_W   = $clog2(NUM_RST)
) (
   input  logic [NUM_RST-1:0] vec_i,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   // Scan from the top down so the last hit written is the lowest index,
   // which gives lowest-index-first release order.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = NUM_RST - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o   = IDX_W'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/glbl_rst_seq.sv
// ----------------------------------------------------------------------------
// glbl_rst_seq
// Consumer end of the global reset control register. Asserts block resets
// immediately and releases them one at a time, lowest index first, with a
// programmable idle gap before each release.
// Ports:
//   clk        in   1        system clock
//   e_reset_n  in   1        external reset, asynchronous, active-low
//   s_reset_n  in   1        soft reset, synchronous, active-low
//   rst_req_n  in   NUM_RST  1 = release requested, 0 = hold block in reset
//   gap_cfg    in   GAP_W    idle cycles inserted before each release
//   rst_out_n  out  NUM_RST  per-block reset, active-low, registered
//   busy       out  1        sequencer active or releases pending
//   cur_idx    out  IDX_W    index currently targeted for release
//   seq_done   out  1        one-cycle pulse when the last pending release lands
// IDX_W is derived from NUM_RST and must not be overridden.
// ----------------------------------------------------------------------------
module glbl_rst_seq
   import glbl_rst_pkg::*;
#(
   parameter int NUM_RST = DEF_NUM_RST,
   parameter int GAP_W   = 8,
   parameter int IDX_W   = $clog2(NUM_RST)
) (
   input  logic               clk,
   input  logic               e_reset_n,
   input  logic               s_reset_n,
   input  logic [NUM_RST-1:0] rst_req_n,
   input  logic [GAP_W-1:0]   gap_cfg,
   output logic [NUM_RST-1:0] rst_out_n,
   output logic               busy,
   output logic [IDX_W-1:0]   cur_idx,
   output logic               seq_done
);

   rst_seq_st_t        state_q, state_d;
   logic [GAP_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   curIdx_q, curIdx_d;
   logic [NUM_RST-1:0] rstOut_q, rstOut_d;
   logic               seqDone_q, seqDone_d;

   logic [NUM_RST-1:0] pending;
   logic [NUM_RST-1:0] curMask;
   logic [IDX_W-1:0]   nextIdx;
   logic               nextValid;
   logic               curReq;

   // Blocks that are requested for release but still held in reset.
   always_comb begin
      pending = rst_req_n & ~rstOut_q;
      curMask = {{(NUM_RST-1){1'b0}}, 1'b1} << curIdx_q;
      curReq  = |(rst_req_n & curMask);
   end

   rst_prio_enc #(
      .NUM_RST (NUM_RST),
      .IDX_W   (IDX_W)
   ) uPrioEnc (
      .vec_i   (pending),
      .idx_o   (nextIdx),
      .valid_o (nextValid)
   );

   // Next-state logic. Assertion is applied first and unconditionally so that
   // a request drop always wins; a release can only set the targeted bit when
   // that bit is still requested, which is the abort check in GAP. The gap
   // counter only decrements while non-zero, so it can never wrap.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      curIdx_d  = curIdx_q;
      rstOut_d  = rstOut_q & rst_req_n;
      seqDone_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (nextValid) begin
               curIdx_d = nextIdx;
               cnt_d    = gap_cfg;
               state_d  = GAP;
            end
         end
         GAP: begin
            if (!curReq) begin
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               rstOut_d  = rstOut_d | curMask;
               seqDone_d = ((pending & ~curMask) == '0);
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. External reset is asynchronous; soft reset is sampled
   // on every edge and forces the same all-asserted idle condition.
   always_ff @(posedge clk or negedge e_reset_n) begin
      if (!e_reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         curIdx_q  <= '0;
         rstOut_q  <= '0;
         seqDone_q <= 1'b0;
      end else if (!s_reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         curIdx_q  <= '0;
         rstOut_q  <= '0;
         seqDone_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         curIdx_q  <= curIdx_d;
         rstOut_q  <= rstOut_d;
         seqDone_q <= seqDone_d;
      end
   end

   // Busy is the only combinational output: it must see a new request in the
   // same cycle it appears on rst_req_n.
   always_comb begin
      busy      = (state_q != IDLE) | (|pending);
      rst_out_n = rstOut_q;
      cur_idx   = curIdx_q;
      seq_done  = seqDone_q;
   end

endmodule
